multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of consecutive wait cycles without mem_ready before a bus error.
REQ-002 The block SHALL have parameter RET_W, default 32, meaning the width of the retired-instruction counter.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction register contents (opcode [6:0], funct3 [14:12], funct7 [31:25])
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, valid with mem_req
- i_or_d  out  1  address select: 0 = PC, 1 = ALU result
- ir_write  out  1  load the instruction register
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by the datapath zero flag
- pc_source  out  1  PC source: 0 = ALU output, 1 = latched ALU result
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  writeback source: 0 = ALU result, 1 = memory data
- alu_src_a  out  2  ALU A source: 00 = PC, 01 = old PC, 10 = rs1
- alu_src_b  out  2  ALU B source: 00 = rs2, 01 = constant 4, 10 = immediate
- alu_ctrl  out  3  ALU operation: 010 = add, 110 = sub, 000 = and, 001 = or
- illegal_instr  out  1  sticky flag: unsupported instruction decoded
- bus_error  out  1  sticky flag: memory timeout
- halted  out  1  FSM is in HALT
- instret  out  RET_W  count of retired instructions
- state  out  4  current state encoding, for debug

Function
REQ-005 The block SHALL be a Moore FSM with these states and encodings: FETCH=0, DECODE=1, EXEC_R=2, R_WB=3, MEM_ADDR=4, MEM_RD=5, LD_WB=6, MEM_WR=7, BRANCH=8, HALT=9.
REQ-006 Every output not asserted by the current state SHALL be 0; outputs are never X.
REQ-007 In FETCH, the block SHALL drive mem_req=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_ctrl=010 and pc_source=0.
REQ-008 In FETCH, ir_write and pc_write SHALL be 1 only in the cycle mem_ready=1, and the FSM SHALL then move to DECODE; otherwise it SHALL stay in FETCH.
REQ-009 In DECODE, the block SHALL drive alu_src_a=01, alu_src_b=10, alu_ctrl=010 (branch target).
REQ-010 From DECODE, the next state SHALL be: opcode 51 -> EXEC_R; opcode 3 or 35 -> MEM_ADDR; opcode 99 -> BRANCH; any other opcode -> HALT with illegal_instr set.
REQ-011 In EXEC_R, the block SHALL drive alu_src_a=10 and alu_src_b=00, with alu_ctrl decoded as follows:
- funct3=0 with funct7=0 -> 010
- funct3=0 with funct7=32 -> 110
- funct3=7 -> 000
- funct3=6 -> 001
REQ-012 Any other funct combination in EXEC_R SHALL cause HALT with illegal_instr set; a legal combination SHALL lead to R_WB.
REQ-013 In R_WB, the block SHALL drive reg_write=1 and mem_to_reg=0, then return to FETCH.
REQ-014 In MEM_ADDR, the block SHALL drive alu_src_a=10, alu_src_b=10 and alu_ctrl=010; the next state SHALL be MEM_RD for opcode 3 and MEM_WR for opcode 35.
REQ-015 In MEM_RD, the block SHALL drive mem_req=1 and i_or_d=1, moving to LD_WB on mem_ready.
REQ-016 In LD_WB, the block SHALL drive reg_write=1 and mem_to_reg=1, then return to FETCH.
REQ-017 In MEM_WR, the block SHALL drive mem_req=1, mem_we=1 and i_or_d=1, moving to FETCH on mem_ready.
REQ-018 In BRANCH, the block SHALL drive alu_src_a=10, alu_src_b=00, alu_ctrl=110, pc_write_cond=1 and pc_source=1, then return to FETCH.
REQ-019 instret SHALL increment by 1 on exit from R_WB, LD_WB, BRANCH, and from MEM_WR on mem_ready, wrapping from 2^RET_W-1 to 0.
REQ-020 A wait counter SHALL clear on entry to FETCH, MEM_RD or MEM_WR, and SHALL increment each cycle in those states while mem_ready=0.
REQ-021 When the wait counter reaches MEM_TIMEOUT with mem_ready=0, the FSM SHALL enter HALT and set bus_error.
REQ-022 mem_ready=1 in the cycle the timeout would fire SHALL complete the access, with no error.
REQ-023 mem_ready asserted in a state with mem_req=0 SHALL be ignored.
REQ-024 HALT SHALL be terminal: halted=1, and all strobes (mem_req, ir_write, pc_write, pc_write_cond, reg_write) remain 0 until reset.
REQ-025 Instruction latency SHALL be the following number of cycles, where N is the number of wait cycles:
- R-type: 4+N
- LD: 5+N
- SD: 4+N
- BEQ: 3+N

Reset
REQ-026 While rst_n=0, the block SHALL immediately force state=FETCH, instret=0, wait counter=0, illegal_instr=0, bus_error=0 and halted=0.
REQ-027 Reset asserted mid-access SHALL abandon the access; mem_req SHALL still be 1 because FETCH is the reset state.
REQ-028 The first FETCH SHALL begin on the first rising clk edge after rst_n deasserts.

Verification
REQ-029 A bench SHALL cover: add (instr=0x002081B3), mem_ready=1 on every request -> states 0,1,2,3,0; alu_ctrl=010 in EXEC_R; reg_write=1 in R_WB; instret=1.
REQ-030 A bench SHALL cover: ld with mem_ready delayed 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then LD_WB with mem_to_reg=1; total 8 cycles.
REQ-031 A bench SHALL cover: sub then beq -> alu_ctrl=110 in both EXEC_R and BRANCH; pc_write_cond=1 for exactly 1 cycle; instret=2.
REQ-032 A bench SHALL cover: opcode 0x13 in the IR -> HALT after DECODE; illegal_instr=1 and halted=1; no further mem_req.
REQ-033 A bench SHALL cover: mem_ready held 0 in FETCH -> bus_error=1 after MEM_TIMEOUT=15 wait cycles; then rst_n pulsed low -> all flags cleared, state=0.
REQ-034 A bench SHALL cover: instret preloaded to 2^32-1 via 2^32-1 retirements (or a forced value) -> one more retirement wraps it to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: Moore FSM sequencing fetch, decode, execute,
// memory access and writeback, with a memory wait timeout and a retire counter.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int RET_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic             illegal_instr,
  output logic             bus_error,
  output logic             halted,
  output logic [RET_W-1:0] instret,
  output logic [3:0]       state
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC <= PC + 4 on mem_ready
  // DECODE   | compute branch target, dispatch on opcode
  // EXEC_R   | register-register ALU operation
  // R_WB     | write ALU result to rd
  // MEM_ADDR | compute load/store address
  // MEM_RD   | data read, waits for mem_ready
  // LD_WB    | write memory data to rd
  // MEM_WR   | data write, waits for mem_ready
  // BRANCH   | compare rs1/rs2, conditional PC load
  // HALT     | terminal after illegal instruction or bus timeout

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_LD_WB    = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  localparam logic [6:0] OP_R  = 7'd51;
  localparam logic [6:0] OP_LD = 7'd3;
  localparam logic [6:0] OP_SD = 7'd35;
  localparam logic [6:0] OP_BR = 7'd99;

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              timeout;
  logic              illegal_set;
  logic              retire;
  logic              r_legal;
  logic [2:0]        r_alu;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    r_legal = 1'b1;
    r_alu   = 3'b000;
    if (funct3 == 3'd0 && funct7 == 7'd0) begin
      r_alu = 3'b010;
    end else if (funct3 == 3'd0 && funct7 == 7'd32) begin
      r_alu = 3'b110;
    end else if (funct3 == 3'd7) begin
      r_alu = 3'b000;
    end else if (funct3 == 3'd6) begin
      r_alu = 3'b001;
    end else begin
      r_legal = 1'b0;
    end
  end

  // Only states that actually drive mem_req may wait or time out.
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout = waiting && !mem_ready && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    retire      = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_HALT;
      end
      S_DECODE: begin
        case (opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_LD, OP_SD: state_d = S_MEM_ADDR;
          OP_BR:        state_d = S_BRANCH;
          default: begin
            state_d     = S_HALT;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        if (r_legal) begin
          state_d = S_R_WB;
        end else begin
          state_d     = S_HALT;
          illegal_set = 1'b1;
        end
      end
      S_R_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_ADDR: begin
        state_d = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_ready)    state_d = S_LD_WB;
        else if (timeout) state_d = S_HALT;
      end
      S_LD_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timeout) begin
          state_d = S_HALT;
        end
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      wait_cnt      <= '0;
      instret       <= '0;
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        wait_cnt <= '0;
      end else if (waiting && !mem_ready) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (retire) instret <= instret + RET_W'(1);
      if (illegal_set) illegal_instr <= 1'b1;
      if (timeout) bus_error <= 1'b1;
    end
  end

  // Outputs decode from the registered state; only the FETCH strobes
  // look at mem_ready so the IR and PC load exactly when data arrives.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_ctrl      = 3'b000;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = 3'b010;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_ctrl  = 3'b010;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_ctrl  = r_alu;
      end
      S_R_WB: begin
        reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        alu_ctrl  = 3'b010;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_LD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b10;
        alu_src_b     = 2'b00;
        alu_ctrl      = 3'b110;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted = (state_q == S_HALT);
  assign state  = state_q;

endmodule
